// File: rtl/data_ram_banked.sv
// rtl/data_ram_banked.sv - byte-lane-banked data RAM with wait states and ce/ack handshake
module data_ram_banked #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH/8-1:0] sel,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    ack_o,
    output logic                    busy_o
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int LB    = $clog2(NB);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [3:0]              r_cnt, w_cnt_nxt;
    logic                    r_we;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [NB-1:0]           r_sel;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_data_o;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic                    w_accept, w_access, w_mem_we;
    logic                    w_acc_we;
    logic [DEPTH_LOG2-1:0]   w_in_idx, w_acc_idx;
    logic [NB-1:0]           w_acc_sel;
    logic [DATA_WIDTH-1:0]   w_acc_wdata;
    logic                    w_unused;

    assign w_in_idx = addr[DEPTH_LOG2+LB-1:LB];
    assign w_unused = ^addr;

    // With zero wait states the access lands on the acceptance edge, so it must use the live inputs.
    assign w_acc_we    = (r_state == S_IDLE) ? we       : r_we;
    assign w_acc_idx   = (r_state == S_IDLE) ? w_in_idx : r_idx;
    assign w_acc_sel   = (r_state == S_IDLE) ? sel      : r_sel;
    assign w_acc_wdata = (r_state == S_IDLE) ? data_i   : r_wdata;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ce) begin
                    w_accept = 1'b1;
                    if (WS == 4'd0) begin
                        w_access    = 1'b1;
                        w_state_nxt = S_ACK;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = WS;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_access    = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Gating with rst keeps an access from landing in memory while reset is held.
    assign w_mem_we = w_access & w_acc_we & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_idx    <= '0;
            r_sel    <= '0;
            r_wdata  <= '0;
            r_data_o <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= we;
                r_idx   <= w_in_idx;
                r_sel   <= sel;
                r_wdata <= data_i;
            end
            if (w_access && !w_acc_we) begin
                r_data_o <= w_rdata;
            end
        end
    end

    for (genvar k = 0; k < NB; k++) begin : g_bank
        logic [7:0] r_bank [DEPTH];

        always_ff @(posedge clk) begin
            if (w_mem_we && w_acc_sel[k]) begin
                r_bank[w_acc_idx] <= w_acc_wdata[8*k +: 8];
            end
        end

        assign w_rdata[8*k +: 8] = r_bank[w_acc_idx];
    end

    assign data_o = r_data_o;
    assign ack_o  = (r_state == S_ACK);
    assign busy_o = (r_state != S_IDLE);
endmodule

// File: doc/data_ram_banked.md
# data_ram_banked

Parametrised, byte-lane-banked data memory with a configurable number of wait states and a request/acknowledge handshake. It sits behind the MEM stage of the openmips core and provides `sb`/`sh`/`sw` byte-enable writes and full-word reads. It replaces the fixed-width, zero-latency single-cycle data RAM so the pipeline can be exercised against slow memory through MEM-stage stalls.

## Interface
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8. `NB = DATA_WIDTH/8` byte lanes (banks).
- `ADDR_WIDTH`, 32: width of the byte address input.
- `DEPTH_LOG2`, 10: log2 of the number of words per bank.
- `WAIT_STATES`, 2: extra cycles inserted before each access; legal range 0..15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `ce`  in  1  request valid.
- `we`  in  1  1 = write, 0 = read; sampled with the request.
- `addr`  in  ADDR_WIDTH  byte address.
- `sel`  in  NB  byte-lane enables for writes; bit k maps to lane k, `data_i[8k+7:8k]`.
- `data_i`  in  DATA_WIDTH  write data.
- `data_o`  out  DATA_WIDTH  read data; valid while `ack_o` = 1 and the access is a read.
- `ack_o`  out  1  access complete; one-cycle pulse.
- `busy_o`  out  1  high in the WAIT and ACK states.

## Operation
- Storage is NB independent banks (`bank0` .. `bank{NB-1}`), each `2^DEPTH_LOG2` × 8 bits.
- Memory contents are not reset and start as X.
- Word index is `addr[DEPTH_LOG2+LB-1 : LB]`, where `LB = log2(NB)`.
  - Low LB bits are ignored; lanes are chosen only by `sel`.
  - Upper address bits are ignored, so addresses alias modulo the depth.
- Write: on the access edge, each bank k with `sel[k]` = 1 stores its lane of the latched data. Other lanes are unchanged.
- Read: on the access edge, `data_o` registers the full word from all lanes, regardless of `sel`.
- FSM states are IDLE, WAIT and ACK.
  - IDLE with `ce` = 1 at an edge: latch `we`, `addr`, `sel` and `data_i`. If `WAIT_STATES` = 0, perform the access and go to ACK. Otherwise go to WAIT with `cnt = WAIT_STATES`.
  - WAIT: each edge decrements `cnt`. At the edge where `cnt` = 1, perform the access and go to ACK.
  - ACK: `ack_o` = 1. The next edge always goes to IDLE, and `ce` is ignored in ACK.
- Inputs are sampled only at acceptance. Changes on `ce`, `addr` or `data_i` during WAIT or ACK have no effect.
- Dropping `ce` in WAIT does not cancel the access; it completes and acks.
- The requester holds `ce` high and stalls until `ack_o`. It then drops `ce`, or keeps it high to issue a new request, which is accepted in the following IDLE cycle.
- `data_o` holds its last read value until the next read access. Writes do not modify `data_o`.

## Timing
- Reset values: state IDLE, `cnt` = 0, `ack_o` = 0, `busy_o` = 0, `data_o` = 0.
- Reset is asynchronous. Asserting `rst` in WAIT aborts the access with no memory write. Asserting it in ACK only clears outputs, since the access has already happened.
- Latency: request accepted at edge E0 → access at edge E0+W (W = `WAIT_STATES`) → `ack_o` high for exactly the cycle between edges E0+W and E0+W+1.
- Minimum request spacing is W+2 cycles: accept, W waits, ACK, back to IDLE. This gives 4 cycles at the default.
- A read issued right after a write to the same word returns the new data; no forwarding hazard exists because accesses are serialised.
- `busy_o` = 1 from edge E0 until edge E0+W+1.

## Test plan
- Byte writes (W=2): 4 write requests to `addr` 0x0..0x3 with `sel` 0001/0010/0100/1000 and lane data 0xFF/0xEE/0xDD/0xCC → each `ack_o` 3 cycles after acceptance. A subsequent read of 0x0 returns 0xCCDDEEFF.
- Half/word merge: write 0x00008899 to 0x4 with `sel` 0011, then 0x44550000 with `sel` 1100 → read of 0x4 returns 0x44558899. Read of 0x6 (same word) returns the same value.
- Zero wait states (W=0): back-to-back requests with `ce` held high → `ack_o` pulses every 2 cycles, and each read has correct data on its ack cycle.
- Input stability: change `addr` and `data_i` and drop `ce` during WAIT → the access uses the latched values and `ack_o` still pulses once.
- Reset mid-operation: pull `rst` low in WAIT of a write of 0xAABBCCDD to 0x8, then release → `ack_o`, `busy_o` and `data_o` are 0 immediately, and a following read of 0x8 returns the prior contents.
- Aliasing and parameters: with DEPTH_LOG2 = 4 and DATA_WIDTH = 64, write 0x11..88 to 0x0 with `sel` = 0xFF → read of 0x80 (alias) returns the same 64-bit word.
